// File: rtl/echo_engine.sv
// echo_engine: feedback/feedforward echo with saturation, delay clamp and history flush
module mybram #(
  parameter int LOGSIZE = 13,
  parameter int WIDTH = 12
) (
  input  logic               clock,
  input  logic [LOGSIZE-1:0] addr,
  input  logic               we,
  input  logic [WIDTH-1:0]   din,
  output logic [WIDTH-1:0]   dout
);
  logic [WIDTH-1:0] mem [2**LOGSIZE];
  always_ff @(posedge clock) begin
    if (we) mem[addr] <= din;
    dout <= mem[addr];
  end
endmodule

module echo_engine #(
  parameter int WIDTH = 12,
  parameter int LOGSIZE = 13,
  parameter int SAMPLES_PER_STEP = 240,
  parameter int DELAY_BITS = 5,
  parameter int GAIN_BITS = 3
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [WIDTH-1:0]      incoming_sample,
  input  logic [DELAY_BITS-1:0] delay_amount,
  input  logic [GAIN_BITS-1:0]  gain,
  input  logic                  mode,
  input  logic                  flush,
  output logic [WIDTH-1:0]      modified_sample,
  output logic                  done,
  output logic                  busy
);
  localparam int PW = WIDTH + GAIN_BITS + 1;
  localparam int SW = WIDTH + 2;
  typedef enum logic [2:0] {FLUSH, IDLE, RD, WT, SCALE, WR} state_t;
  state_t state_q, state_d;
  logic [LOGSIZE-1:0] cnt_q, cnt_d, wr_ptr_q, wr_ptr_d, rd_addr, mem_addr, d_clamp;
  logic [WIDTH-1:0] x_q, x_d, y_q, y_d, mem_din, mem_dout, y_sat;
  logic [DELAY_BITS-1:0] delay_q, delay_d;
  logic [GAIN_BITS-1:0] gain_q, gain_d;
  logic mode_q, mode_d, done_q, done_d, mem_we;
  logic signed [PW-1:0] p_q, p_d, p_sh;
  logic signed [SW-1:0] s;
  logic [31:0] d_full;

  assign d_full = 32'(delay_q) * 32'(SAMPLES_PER_STEP);
  assign d_clamp = (d_full > 32'(2**LOGSIZE - 1)) ? '1 : d_full[LOGSIZE-1:0];
  assign rd_addr = wr_ptr_q - d_clamp;
  assign p_sh = p_q >>> GAIN_BITS;
  assign s = $signed({{2{x_q[WIDTH-1]}}, x_q}) + SW'(p_sh);
  // top three bits disagree only when the sum left the WIDTH-bit range
  assign y_sat = (s[SW-1:WIDTH-1] == '0 || s[SW-1:WIDTH-1] == '1) ? s[WIDTH-1:0]
               : {s[SW-1], {(WIDTH-1){~s[SW-1]}}};
  assign mem_we = state_q == FLUSH || state_q == WR;
  assign mem_addr = state_q == FLUSH ? cnt_q : state_q == WR ? wr_ptr_q : rd_addr;
  assign mem_din = state_q == WR ? (mode_q ? x_q : y_sat) : '0;
  assign modified_sample = y_q;
  assign done = done_q;
  assign busy = state_q != IDLE;

  mybram #(.LOGSIZE(LOGSIZE), .WIDTH(WIDTH)) u_bram (
    .clock(clock), .addr(mem_addr), .we(mem_we), .din(mem_din), .dout(mem_dout)
  );

  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    wr_ptr_d = wr_ptr_q;
    x_d = x_q;
    delay_d = delay_q;
    gain_d = gain_q;
    mode_d = mode_q;
    p_d = p_q;
    y_d = y_q;
    done_d = 1'b0;
    case (state_q)
      FLUSH: begin
        cnt_d = cnt_q + LOGSIZE'(1);
        if (cnt_q == '1) begin
          state_d = IDLE;
          wr_ptr_d = '0;
        end
      end
      IDLE: begin
        if (flush) begin
          state_d = FLUSH;
          cnt_d = '0;
        end else if (start) begin
          state_d = RD;
          x_d = incoming_sample;
          delay_d = delay_amount;
          gain_d = gain;
          mode_d = mode;
        end
      end
      RD: state_d = WT;
      WT: state_d = SCALE;
      SCALE: begin
        // zero delay is a bypass, so the tap contributes nothing
        p_d = delay_q == '0 ? '0 : PW'($signed(mem_dout)) * PW'($signed({1'b0, gain_q}));
        state_d = WR;
      end
      WR: begin
        y_d = y_sat;
        done_d = 1'b1;
        wr_ptr_d = wr_ptr_q + LOGSIZE'(1);
        state_d = IDLE;
      end
      default: state_d = FLUSH;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= FLUSH;
      cnt_q <= '0;
      wr_ptr_q <= '0;
      x_q <= '0;
      delay_q <= '0;
      gain_q <= '0;
      mode_q <= 1'b0;
      p_q <= '0;
      y_q <= '0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      wr_ptr_q <= wr_ptr_d;
      x_q <= x_d;
      delay_q <= delay_d;
      gain_q <= gain_d;
      mode_q <= mode_d;
      p_q <= p_d;
      y_q <= y_d;
      done_q <= done_d;
    end
  end
endmodule

// File: tb/tb_echo_engine.sv
// tb_echo_engine: random and directed stimulus against a transaction-level echo model
module tb_echo_engine;
  localparam int W = 12, LS = 6, SPS = 4, DB = 5, GB = 3, DEPTH = 64;
  logic clock = 1'b0, reset = 1'b1, start = 1'b0, mode = 1'b0, flush = 1'b0;
  logic [W-1:0] incoming_sample = '0;
  logic [DB-1:0] delay_amount = '0;
  logic [GB-1:0] gain = '0;
  logic [W-1:0] modified_sample;
  logic done, busy;
  int checks = 0, errors = 0;
  int hist[DEPTH];
  int wp, rem, pend, pend_y, exp_ms;
  int mx, md, mm, me, ms, mg;
  bit exp_done, started;
  int ys[$];

  always #5 clock = ~clock;

  echo_engine #(.WIDTH(W), .LOGSIZE(LS), .SAMPLES_PER_STEP(SPS), .DELAY_BITS(DB), .GAIN_BITS(GB)) dut (
    .clock(clock), .reset(reset), .start(start), .incoming_sample(incoming_sample),
    .delay_amount(delay_amount), .gain(gain), .mode(mode), .flush(flush),
    .modified_sample(modified_sample), .done(done), .busy(busy)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // reference: an accepted sample keeps the block busy 4 more edges, a flush or reset 64
  initial begin
    forever begin
      @(posedge clock);
      started = 1;
      if (reset) begin
        rem = DEPTH; pend = 0; exp_done = 0; exp_ms = 0; wp = 0;
        foreach (hist[i]) hist[i] = 0;
      end else begin
        exp_done = 0;
        if (pend > 0) begin
          pend--;
          if (pend == 0) begin exp_done = 1; exp_ms = pend_y; end
        end
        if (rem > 0) rem--;
        else if (flush) begin
          rem = DEPTH; wp = 0;
          foreach (hist[i]) hist[i] = 0;
        end else if (start) begin
          mx = $signed(incoming_sample);
          mg = gain;
          md = SPS * delay_amount;
          if (md > DEPTH - 1) md = DEPTH - 1;
          mm = hist[(wp - md) & (DEPTH - 1)];
          me = (delay_amount == 0) ? 0 : (mm * mg) >>> GB;
          ms = mx + me;
          if (ms > 2047) ms = 2047;
          if (ms < -2048) ms = -2048;
          hist[wp] = mode ? mx : ms;
          wp = (wp + 1) % DEPTH;
          pend = 4; pend_y = ms; rem = 4;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clock);
      if (started) begin
        chk("done", done, exp_done);
        chk("busy", busy, rem > 0);
        chk("modified_sample", $signed(modified_sample), exp_ms);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic sample(input int x, output int y);
    start = 1'b1;
    incoming_sample = W'(x);
    @(negedge clock);
    start = 1'b0;
    repeat (4) @(negedge clock);
    chk("latency_done", done, 1);
    y = $signed(modified_sample);
  endtask

  task automatic count_busy(output int n);
    n = 0;
    while (busy === 1'b1 && n < 300) begin
      n++;
      @(negedge clock);
    end
  endtask

  task automatic do_flush();
    int n;
    flush = 1'b1;
    @(negedge clock);
    flush = 1'b0;
    count_busy(n);
    chk("flush_len", n, 64);
  endtask

  task automatic run(input int n, input int x0, input int xr);
    int y;
    ys.delete();
    for (int i = 0; i < n; i++) begin
      sample(i == 0 ? x0 : xr, y);
      ys.push_back(y);
    end
  endtask

  initial begin
    int n, y;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 300) begin
      start = (n == 10);
      n++;
      @(negedge clock);
    end
    start = 1'b0;
    chk("reset_flush_len", n, 64);
    delay_amount = 1; gain = 7; mode = 0;
    sample(100, y);
    chk("post_flush_y", y, 100);

    do_flush();
    run(16, 800, 0);
    chk("fb_y0", ys[0], 800);
    chk("fb_y4", ys[4], 700);
    chk("fb_y8", ys[8], 612);
    chk("fb_y12", ys[12], 535);
    chk("fb_y5", ys[5], 0);

    do_flush();
    mode = 1;
    run(12, 800, 0);
    chk("ff_y0", ys[0], 800);
    chk("ff_y4", ys[4], 700);
    chk("ff_y8", ys[8], 0);

    do_flush();
    mode = 0;
    run(5, 2000, 2000);
    chk("sat_pos", ys[4], 2047);
    do_flush();
    run(5, -2000, -2000);
    chk("sat_neg", ys[4], -2048);
    do_flush();
    gain = 1;
    run(5, -1, 0);
    chk("floor", ys[4], -1);

    do_flush();
    gain = 7; delay_amount = 31;
    run(200, 800, 0);
    chk("clamp_y62", ys[62], 0);
    chk("clamp_y63", ys[63], 700);
    chk("wrap_y126", ys[126], 612);
    chk("wrap_y189", ys[189], 535);

    delay_amount = 0;
    start = 1'b1; incoming_sample = W'(300);
    @(negedge clock);
    start = 1'b0;
    @(negedge clock);
    start = 1'b1; incoming_sample = W'(555);
    @(negedge clock);
    start = 1'b0;
    @(negedge clock);
    @(negedge clock);
    chk("wt_start_done", done, 1);
    chk("wt_start_y", $signed(modified_sample), 300);

    start = 1'b1; incoming_sample = W'(400);
    @(negedge clock);
    start = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("rst_scale_y", $signed(modified_sample), 0);
    chk("rst_scale_done", done, 0);
    count_busy(n);
    chk("rst_scale_busy", n, 64);

    for (int i = 0; i < 1500; i++) begin
      start = ($urandom % 3 == 0);
      flush = ($urandom % 60 == 0);
      reset = ($urandom % 400 == 0);
      incoming_sample = W'($urandom);
      delay_amount = ($urandom % 2 == 0) ? DB'($urandom_range(0, 3)) : DB'($urandom);
      gain = GB'($urandom);
      mode = 1'($urandom);
      @(negedge clock);
    end
    start = 1'b0; flush = 1'b0; reset = 1'b0;
    repeat (80) @(negedge clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
